// File: rtl/axis_frame_gen_pkg.sv
// Shared types and constants for the AXI4-Stream test frame generator.
package axis_frame_gen_pkg;

  localparam int unsigned DATA_WIDTH_DFLT = 8;
  localparam int unsigned LEN_WIDTH_DFLT  = 16;
  localparam int unsigned CNT_WIDTH_DFLT  = 32;

  // Saturation value of a statistics counter at the default width
  localparam logic [CNT_WIDTH_DFLT-1:0] CNT_ALL_ONES = '1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/axis_stat_counter.sv
// Saturating event counter; a clear wins over a same-cycle increment.
module axis_stat_counter #(
  parameter int unsigned CNT_WIDTH = axis_frame_gen_pkg::CNT_WIDTH_DFLT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/axis_frame_gen.sv
// Command-driven AXI4-Stream frame source with FIFO status statistics.
module axis_frame_gen
  import axis_frame_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DFLT,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DFLT,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DFLT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_seed,
  input  logic                  cmd_bad,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  st_overflow,
  input  logic                  st_bad_frame,
  input  logic                  st_good_frame,
  input  logic                  cnt_clear,
  output logic                  busy,
  output logic                  zero_len_err,
  output logic [CNT_WIDTH-1:0]  frames_sent,
  output logic [CNT_WIDTH-1:0]  frames_good,
  output logic [CNT_WIDTH-1:0]  frames_bad,
  output logic [CNT_WIDTH-1:0]  frames_ovf
);

  state_e                state;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  idx_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic                  bad_q;

  logic                  xfer;
  logic                  xfer_last;
  logic                  accept;
  logic [LEN_WIDTH-1:0]  idx_nx;
  logic                  last_nx;

  assign xfer      = m_axis_tvalid && m_axis_tready;
  assign xfer_last = xfer && m_axis_tlast;
  // Ready in the last-beat cycle lets the next frame follow with no bubble
  assign cmd_ready = rst_n && ((state == IDLE) || xfer_last);
  assign accept    = cmd_valid && cmd_ready;
  assign idx_nx    = idx_q + LEN_WIDTH'(1);
  assign last_nx   = (idx_nx == (len_q - LEN_WIDTH'(1)));
  assign busy      = (state == SEND);

  // Frame FSM and registered stream outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      len_q         <= '0;
      idx_q         <= '0;
      seed_q        <= '0;
      bad_q         <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      zero_len_err  <= 1'b0;
    end else begin
      zero_len_err <= accept && (cmd_len == '0);
      if (accept && (cmd_len != '0)) begin
        state         <= SEND;
        len_q         <= cmd_len;
        seed_q        <= cmd_seed;
        bad_q         <= cmd_bad;
        idx_q         <= '0;
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= cmd_seed;
        m_axis_tlast  <= (cmd_len == LEN_WIDTH'(1));
        m_axis_tuser  <= cmd_bad && (cmd_len == LEN_WIDTH'(1));
      end else if (xfer_last) begin
        state         <= IDLE;
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        m_axis_tuser  <= 1'b0;
      end else if ((state == SEND) && xfer) begin
        idx_q        <= idx_nx;
        m_axis_tdata <= seed_q + DATA_WIDTH'(idx_nx);
        m_axis_tlast <= last_nx;
        m_axis_tuser <= bad_q && last_nx;
      end
    end
  end

  axis_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_sent (
    .clk(clk), .rst_n(rst_n), .inc(xfer_last), .clr(cnt_clear), .cnt(frames_sent)
  );

  axis_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_good (
    .clk(clk), .rst_n(rst_n), .inc(st_good_frame), .clr(cnt_clear), .cnt(frames_good)
  );

  axis_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_bad (
    .clk(clk), .rst_n(rst_n), .inc(st_bad_frame), .clr(cnt_clear), .cnt(frames_bad)
  );

  axis_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_ovf (
    .clk(clk), .rst_n(rst_n), .inc(st_overflow), .clr(cnt_clear), .cnt(frames_ovf)
  );

endmodule

// File: tb/tb_axis_frame_gen.sv
// Randomized bench for axis_frame_gen against a beat-queue reference model.
module tb_axis_frame_gen;

  localparam int unsigned DW   = 8;
  localparam int unsigned LW   = 8;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] cmd_seed;
  logic          cmd_bad;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          st_overflow;
  logic          st_bad_frame;
  logic          st_good_frame;
  logic          cnt_clear;
  logic          busy;
  logic          zero_len_err;
  logic [CW-1:0] frames_sent;
  logic [CW-1:0] frames_good;
  logic [CW-1:0] frames_bad;
  logic [CW-1:0] frames_ovf;

  axis_frame_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_len(cmd_len), .cmd_seed(cmd_seed), .cmd_bad(cmd_bad),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .st_overflow(st_overflow), .st_bad_frame(st_bad_frame),
    .st_good_frame(st_good_frame), .cnt_clear(cnt_clear),
    .busy(busy), .zero_len_err(zero_len_err),
    .frames_sent(frames_sent), .frames_good(frames_good),
    .frames_bad(frames_bad), .frames_ovf(frames_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: the beats still owed to the sink, plus counter values
  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic          u;
  } beat_t;

  beat_t q[$];
  int    m_sent, m_good, m_bad, m_ovf;
  bit    zl_pend;
  bit    exp_ready, did_last;

  function automatic int sat(input int v, input bit inc, input bit clr);
    if (clr) return 0;
    if (inc && v < CMAX) return v + 1;
    return v;
  endfunction

  function automatic void push_frame(input int len, input int seed, input bit bad);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = DW'((seed + i) % 256);
      b.l = (i == len - 1);
      b.u = bad && (i == len - 1);
      q.push_back(b);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("ready_in_reset", 32'(cmd_ready), 32'd0);
      q.delete();
      m_sent = 0; m_good = 0; m_bad = 0; m_ovf = 0;
      zl_pend = 1'b0;
    end else begin
      check("tvalid", 32'(m_axis_tvalid), 32'(q.size() > 0));
      check("busy", 32'(busy), 32'(q.size() > 0));
      if (q.size() > 0) begin
        check("tdata", 32'(m_axis_tdata), 32'(q[0].d));
        check("tlast", 32'(m_axis_tlast), 32'(q[0].l));
        check("tuser", 32'(m_axis_tuser), 32'(q[0].u));
      end
      exp_ready = (q.size() == 0) || (q.size() == 1 && m_axis_tready);
      check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
      check("zero_len_err", 32'(zero_len_err), 32'(zl_pend));
      check("frames_sent", 32'(frames_sent), 32'(m_sent));
      check("frames_good", 32'(frames_good), 32'(m_good));
      check("frames_bad", 32'(frames_bad), 32'(m_bad));
      check("frames_ovf", 32'(frames_ovf), 32'(m_ovf));
      zl_pend  = 1'b0;
      did_last = 1'b0;
      if (m_axis_tready && q.size() > 0) begin
        did_last = q[0].l;
        void'(q.pop_front());
      end
      m_sent = sat(m_sent, did_last, cnt_clear);
      m_good = sat(m_good, st_good_frame, cnt_clear);
      m_bad  = sat(m_bad, st_bad_frame, cnt_clear);
      m_ovf  = sat(m_ovf, st_overflow, cnt_clear);
      if (cmd_valid && exp_ready) begin
        if (cmd_len == '0) zl_pend = 1'b1;
        else push_frame(int'(cmd_len), int'(cmd_seed), cmd_bad);
      end
    end
  end

  // Sink ready pattern: 0 always ready, 1 repeating 1,0,0, 2 random
  int rdy_mode = 0;
  always @(posedge clk) begin
    int ph;
    #1;
    ph = (ph + 1) % 3;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = (ph == 0);
      default: m_axis_tready = ($urandom_range(0, 9) < 7);
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int len, input int seed, input bit bad);
    bit acc = 1'b0;
    cmd_len   = LW'(len);
    cmd_seed  = DW'(seed);
    cmd_bad   = bad;
    cmd_valid = 1'b1;
    for (int i = 0; i < 2000 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    if (!acc) check("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      done = (q.size() == 0) && !m_axis_tvalid;
      step();
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit acc;
    rst_n = 1'b0;
    cmd_len = '0; cmd_seed = '0; cmd_bad = 1'b0; cmd_valid = 1'b0;
    st_overflow = 1'b0; st_bad_frame = 1'b0; st_good_frame = 1'b0; cnt_clear = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_tdata", 32'(m_axis_tdata), 32'd0);
    check("reset_tlast", 32'(m_axis_tlast), 32'd0);
    check("reset_tuser", 32'(m_axis_tuser), 32'd0);
    step();

    // Data wrap across 0xFF with a continuously ready sink
    send_cmd(4, 8'hFE, 1'b0);
    wait_idle();
    // Bad frame under a stalling sink
    rdy_mode = 1;
    send_cmd(3, 8'h10, 1'b1);
    wait_idle();
    rdy_mode = 0;
    // Back-to-back commands, then single-beat and zero-length
    send_cmd(2, 8'h20, 1'b0);
    send_cmd(1, 8'h30, 1'b1);
    wait_idle();
    send_cmd(0, 8'h40, 1'b0);
    step();
    step();
    // Longest frame
    rdy_mode = 2;
    send_cmd(255, 8'h80, 1'b1);
    wait_idle();
    rdy_mode = 0;

    // Saturation of frames_good, then clear against a same-cycle bad pulse
    cnt_clear = 1'b1; step(); cnt_clear = 1'b0;
    st_good_frame = 1'b1;
    repeat (CMAX - 1 + 3) step();
    st_good_frame = 1'b0;
    st_bad_frame = 1'b1; step(); step();
    cnt_clear = 1'b1; step();
    cnt_clear = 1'b0; st_bad_frame = 1'b0;
    step();

    // Reset on the second beat of a five-beat frame
    send_cmd(5, 8'h55, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();

    // Randomized traffic, status pulses and occasional clears
    rdy_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = cmd_valid && cmd_ready;
      step();
      if (acc || !cmd_valid) begin
        cmd_valid = ($urandom_range(0, 2) != 0);
        cmd_len   = ($urandom_range(0, 9) == 0) ? LW'(0) : LW'($urandom_range(1, 6));
        cmd_seed  = DW'($urandom);
        cmd_bad   = 1'($urandom_range(0, 1));
      end
      st_overflow   = ($urandom_range(0, 3) == 0);
      st_bad_frame  = ($urandom_range(0, 3) == 0);
      st_good_frame = ($urandom_range(0, 3) == 0);
      cnt_clear     = ($urandom_range(0, 49) == 0);
    end
    cmd_valid = 1'b0;
    st_overflow = 1'b0; st_bad_frame = 1'b0; st_good_frame = 1'b0; cnt_clear = 1'b0;
    wait_idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
